// File: rtl/npu_v2_set_reset_ctrl.sv
// npu_v2_set_reset_ctrl
// ---------------------------------------------------------------------------
// Host-side sequencer that programs one NPU_v2 crossbar cell with a single
// SET or RESET pulse. For each command it:
//   1. shifts a one-hot token into the WL and BL ring-switch chains,
//   2. arms the overall switches,
//   3. pulses DACBL_SW,
//   4. disarms,
//   5. optionally reads the cell weight back through the ADC port.
//
// Optional feature macro: NPU_CTRL_READBACK_EN
//   defined   : READ_ADDR/READ_CLK states exist; rsp_data carries sampled DOUT
//   undefined : DISARM goes straight to DONE; rsp_data, ADDR, CLKADC stay 0
//
// Ports
//   clk_all, reset_all            : clock, synchronous active-low reset
//   cmd_valid/cmd_ready           : command handshake (op/wl/bl payload)
//   cmd_op                        : 1 = SET, 0 = RESET
//   cmd_wl, cmd_bl                : target cell indices
//   rsp_valid/rsp_err/rsp_data    : one-cycle completion pulse with status/data
//   CLKREG, DINSWREG              : ring-chain clock/data (bit0 = WL, bit3 = BL)
//   DACWL_SW, DACSEL_SW, DACWLREFSW,
//   DACBL_SW, SET, RESET          : pulse switches
//   ADDR, CLKADC, DOUT            : readback address, strobe, array data
//   CLKDAC, DACBL_SW2, CLKADCSW,
//   DISCHG, DIN                   : unused array pins, tied low
//   o_dbg_state                   : current FSM state for observation
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
// cmd_ready is high only in IDLE, and cmd_valid is ignored everywhere else.
// There is no queueing. rsp_valid is a one-cycle pulse with no back-pressure.
// rsp_err and rsp_data are meaningful while rsp_valid is high.
// ---------------------------------------------------------------------------
module npu_v2_set_reset_ctrl #(
  parameter int MAX_NUM_WL       = 256,
  parameter int MAX_NUM_BL       = 256,
  parameter int OUTPUT_DATAWIDTH = 6,
  parameter int ARM_CYCLES       = 2,
  parameter int PULSE_CYCLES     = 4
) (
  input  logic                        clk_all,
  input  logic                        reset_all,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_op,
  input  logic [8:0]                  cmd_wl,
  input  logic [8:0]                  cmd_bl,
  output logic                        rsp_valid,
  output logic                        rsp_err,
  output logic [OUTPUT_DATAWIDTH-1:0] rsp_data,
  output logic [3:0]                  CLKREG,
  output logic [3:0]                  DINSWREG,
  output logic                        DACWL_SW,
  output logic                        DACSEL_SW,
  output logic                        DACWLREFSW,
  output logic                        DACBL_SW,
  output logic                        SET,
  output logic                        RESET,
  output logic [8:0]                  ADDR,
  output logic                        CLKADC,
  input  logic [OUTPUT_DATAWIDTH-1:0] DOUT,
  output logic                        CLKDAC,
  output logic                        DACBL_SW2,
  output logic                        CLKADCSW,
  output logic                        DISCHG,
  output logic [7:0]                  DIN,
  output logic [3:0]                  o_dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_SHIFT_SETUP = 4'd1,
    S_SHIFT_CLK   = 4'd2,
    S_ARM         = 4'd3,
    S_PULSE       = 4'd4,
    S_DISARM      = 4'd5,
    S_READ_ADDR   = 4'd6,
    S_READ_CLK    = 4'd7,
    S_DONE        = 4'd8
  } state_t;

  localparam logic [8:0]  LP_LAST_WL    = 9'(MAX_NUM_WL - 1);
  localparam logic [8:0]  LP_LAST_BL    = 9'(MAX_NUM_BL - 1);
  localparam logic [15:0] LP_ARM_LAST   = 16'(ARM_CYCLES - 1);
  localparam logic [15:0] LP_PULSE_LAST = 16'(PULSE_CYCLES - 1);

  state_t      r_state;
  logic [8:0]  r_k;
  logic [15:0] r_cnt;
  logic        r_op;
  logic [8:0]  r_wl;
  logic [8:0]  r_bl;

  logic        w_cmd_oor;

  assign w_cmd_oor = ({23'd0, cmd_wl} >= 32'(MAX_NUM_WL)) ||
                     ({23'd0, cmd_bl} >= 32'(MAX_NUM_BL));

  // Data bits for shift step k. The chain bit pushed at step k ends up at
  // index MAX-1-k once all MAX steps are done, so the token is pushed on the
  // step where MAX-1-k equals the target index.
  function automatic logic [3:0] din_bits(input logic [8:0] k,
                                          input logic [8:0] wl,
                                          input logic [8:0] bl);
    logic [3:0] b;
    b    = 4'b0000;
    b[0] = ((LP_LAST_WL - k) == wl);
    b[3] = ((LP_LAST_BL - k) == bl);
    return b;
  endfunction

  always_ff @(posedge clk_all) begin
    if (!reset_all) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_cnt      <= '0;
      r_op       <= 1'b0;
      r_wl       <= '0;
      r_bl       <= '0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_data   <= '0;
      CLKREG     <= 4'b0000;
      DINSWREG   <= 4'b0000;
      DACWL_SW   <= 1'b0;
      DACSEL_SW  <= 1'b0;
      DACWLREFSW <= 1'b0;
      DACBL_SW   <= 1'b0;
      SET        <= 1'b0;
      RESET      <= 1'b0;
      ADDR       <= '0;
      CLKADC     <= 1'b0;
    end else begin
      // Every pin defaults low. Each state re-asserts what it needs, so the
      // outputs always describe the state being entered.
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      CLKREG     <= 4'b0000;
      DINSWREG   <= 4'b0000;
      DACWL_SW   <= 1'b0;
      DACSEL_SW  <= 1'b0;
      DACWLREFSW <= 1'b0;
      DACBL_SW   <= 1'b0;
      SET        <= 1'b0;
      RESET      <= 1'b0;
      ADDR       <= '0;
      CLKADC     <= 1'b0;

      case (r_state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            r_op      <= cmd_op;
            r_wl      <= cmd_wl;
            r_bl      <= cmd_bl;
            r_k       <= '0;
            if (w_cmd_oor) begin
              // Bad index: answer immediately without touching any array pin.
              r_state   <= S_DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
            end else begin
              r_state  <= S_SHIFT_SETUP;
              rsp_err  <= 1'b0;
              DINSWREG <= din_bits(9'd0, cmd_wl, cmd_bl);
            end
          end
        end

        S_SHIFT_SETUP: begin
          r_state  <= S_SHIFT_CLK;
          CLKREG   <= 4'b1001;
          DINSWREG <= DINSWREG;
        end

        S_SHIFT_CLK: begin
          if (r_k == LP_LAST_WL) begin
            r_state    <= S_ARM;
            r_cnt      <= '0;
            DACWL_SW   <= 1'b1;
            DACSEL_SW  <= 1'b1;
            DACWLREFSW <= 1'b1;
            SET        <= r_op;
            RESET      <= !r_op;
          end else begin
            r_k      <= r_k + 9'd1;
            r_state  <= S_SHIFT_SETUP;
            DINSWREG <= din_bits(r_k + 9'd1, r_wl, r_bl);
          end
        end

        S_ARM: begin
          DACWL_SW   <= 1'b1;
          DACSEL_SW  <= 1'b1;
          DACWLREFSW <= 1'b1;
          SET        <= r_op;
          RESET      <= !r_op;
          if (r_cnt == LP_ARM_LAST) begin
            r_state  <= S_PULSE;
            r_cnt    <= '0;
            DACBL_SW <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_PULSE: begin
          DACWL_SW   <= 1'b1;
          DACSEL_SW  <= 1'b1;
          DACWLREFSW <= 1'b1;
          SET        <= r_op;
          RESET      <= !r_op;
          if (r_cnt == LP_PULSE_LAST) begin
            r_state <= S_DISARM;
          end else begin
            r_cnt    <= r_cnt + 16'd1;
            DACBL_SW <= 1'b1;
          end
        end

        S_DISARM: begin
`ifdef NPU_CTRL_READBACK_EN
          r_state <= S_READ_ADDR;
          ADDR    <= r_bl;
`else
          r_state   <= S_DONE;
          rsp_valid <= 1'b1;
          rsp_data  <= '0;
`endif
        end

`ifdef NPU_CTRL_READBACK_EN
        S_READ_ADDR: begin
          r_state <= S_READ_CLK;
          ADDR    <= r_bl;
          CLKADC  <= 1'b1;
        end

        S_READ_CLK: begin
          // DOUT is captured on the edge that closes the CLKADC high cycle.
          r_state   <= S_DONE;
          rsp_valid <= 1'b1;
          rsp_data  <= DOUT;
        end
`endif

        S_DONE: begin
          r_state   <= S_IDLE;
          cmd_ready <= 1'b1;
        end

        default: begin
          r_state   <= S_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

`ifndef NPU_CTRL_READBACK_EN
  logic w_unused_dout;
  assign w_unused_dout = ^DOUT;
`endif

  assign CLKDAC      = 1'b0;
  assign DACBL_SW2   = 1'b0;
  assign CLKADCSW    = 1'b0;
  assign DISCHG      = 1'b0;
  assign DIN         = 8'd0;
  assign o_dbg_state = r_state;

endmodule
